// File: rtl/axi_lite_arbiter_pkg.sv
// axi_lite_arbiter_pkg: shared AXI-Lite types and arbiter FSM states
package axi_lite_arbiter_pkg;
    typedef logic [2:0] prot_t;
    typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_RESP} arb_state_t;
endpackage

// File: rtl/axi_lite_channel.sv
// axi_lite_channel: AXI-Lite bundle with master/slave views
interface axi_lite_channel
    import axi_lite_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
) ();
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    prot_t                   aw_prot;
    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    b_valid;
    logic                    b_ready;
    resp_t                   b_resp;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    prot_t                   ar_prot;
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    resp_t                   r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_prot, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
    modport slave (
        input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_prot, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant_oh,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    // scan farthest-first so the nearest requester after ptr is the last write
    always_comb begin
        grant_idx = '0;
        grant_valid = 1'b0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant_idx = idx;
                grant_valid = 1'b1;
            end
        end
        grant_oh = grant_valid ? (N'(1) << grant_idx) : '0;
    end
endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: N:1 AXI-Lite arbiter, independent round-robin read and write paths
module axi_lite_arbiter
    import axi_lite_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    axi_lite_channel.slave                 up [NUM_MASTERS],
    axi_lite_channel.master                down,
    output logic [$clog2(NUM_MASTERS)-1:0] wr_grant,
    output logic [$clog2(NUM_MASTERS)-1:0] rd_grant
);
    localparam int N  = NUM_MASTERS;
    localparam int IW = $clog2(N);
    localparam int SW = DATA_WIDTH / 8;

    if (N < 2) begin : g_bad_n
        $fatal(1, "axi_lite_arbiter: NUM_MASTERS must be >= 2");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $fatal(1, "axi_lite_arbiter: DATA_WIDTH must be 32 or 64");
    end

    logic [N-1:0]          aw_valid_v, w_valid_v, ar_valid_v, b_ready_v, r_ready_v;
    logic [ADDR_WIDTH-1:0] aw_addr_v [N];
    logic [ADDR_WIDTH-1:0] ar_addr_v [N];
    prot_t                 aw_prot_v [N];
    prot_t                 ar_prot_v [N];
    logic [DATA_WIDTH-1:0] w_data_v [N];
    logic [SW-1:0]         w_strb_v [N];

    arb_state_t    wr_state, wr_next, rd_state, rd_next;
    logic [IW-1:0] wr_ptr, rd_ptr, wr_pick, rd_pick;
    logic [N-1:0]  wr_oh, rd_oh, wr_pick_oh, rd_pick_oh;
    logic          wr_req_any, rd_req_any, aw_done, w_done;
    logic          aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic          aw_go, w_go, b_go, ar_go, r_go;

    rr_arbiter #(.N(N)) u_wr_arb (
        .req(aw_valid_v | w_valid_v), .ptr(wr_ptr),
        .grant_oh(wr_pick_oh), .grant_idx(wr_pick), .grant_valid(wr_req_any)
    );
    rr_arbiter #(.N(N)) u_rd_arb (
        .req(ar_valid_v), .ptr(rd_ptr),
        .grant_oh(rd_pick_oh), .grant_idx(rd_pick), .grant_valid(rd_req_any)
    );

    // only the registered owner ever sees readys or response valids
    for (genvar i = 0; i < N; i++) begin : g_up
        assign aw_valid_v[i]   = up[i].aw_valid;
        assign aw_addr_v[i]    = up[i].aw_addr;
        assign aw_prot_v[i]    = up[i].aw_prot;
        assign w_valid_v[i]    = up[i].w_valid;
        assign w_data_v[i]     = up[i].w_data;
        assign w_strb_v[i]     = up[i].w_strb;
        assign b_ready_v[i]    = up[i].b_ready;
        assign ar_valid_v[i]   = up[i].ar_valid;
        assign ar_addr_v[i]    = up[i].ar_addr;
        assign ar_prot_v[i]    = up[i].ar_prot;
        assign r_ready_v[i]    = up[i].r_ready;
        assign up[i].aw_ready  = wr_oh[i] & aw_rdy;
        assign up[i].w_ready   = wr_oh[i] & w_rdy;
        assign up[i].b_valid   = wr_oh[i] & b_vld;
        assign up[i].b_resp    = down.b_resp;
        assign up[i].ar_ready  = rd_oh[i] & ar_rdy;
        assign up[i].r_valid   = rd_oh[i] & r_vld;
        assign up[i].r_data    = down.r_data;
        assign up[i].r_resp    = down.r_resp;
    end

    assign down.aw_valid = (wr_state == ARB_ADDR) & !aw_done & aw_valid_v[wr_grant];
    assign down.aw_addr  = aw_addr_v[wr_grant];
    assign down.aw_prot  = aw_prot_v[wr_grant];
    assign down.w_valid  = (wr_state == ARB_ADDR) & !w_done & w_valid_v[wr_grant];
    assign down.w_data   = w_data_v[wr_grant];
    assign down.w_strb   = w_strb_v[wr_grant];
    assign down.b_ready  = (wr_state == ARB_RESP) & b_ready_v[wr_grant];
    assign down.ar_valid = (rd_state == ARB_ADDR) & ar_valid_v[rd_grant];
    assign down.ar_addr  = ar_addr_v[rd_grant];
    assign down.ar_prot  = ar_prot_v[rd_grant];
    assign down.r_ready  = (rd_state == ARB_RESP) & r_ready_v[rd_grant];

    assign aw_rdy = (wr_state == ARB_ADDR) & down.aw_ready & !aw_done;
    assign w_rdy  = (wr_state == ARB_ADDR) & down.w_ready & !w_done;
    assign b_vld  = (wr_state == ARB_RESP) & down.b_valid;
    assign ar_rdy = (rd_state == ARB_ADDR) & down.ar_ready;
    assign r_vld  = (rd_state == ARB_RESP) & down.r_valid;
    assign aw_go  = down.aw_valid & down.aw_ready;
    assign w_go   = down.w_valid & down.w_ready;
    assign b_go   = down.b_valid & down.b_ready;
    assign ar_go  = down.ar_valid & down.ar_ready;
    assign r_go   = down.r_valid & down.r_ready;

    always_comb begin
        wr_next = (wr_state == ARB_IDLE) ? (wr_req_any ? ARB_ADDR : ARB_IDLE)
                : (wr_state == ARB_ADDR) ? (((aw_done | aw_go) & (w_done | w_go)) ? ARB_RESP : ARB_ADDR)
                : (b_go ? ARB_IDLE : ARB_RESP);
        rd_next = (rd_state == ARB_IDLE) ? (rd_req_any ? ARB_ADDR : ARB_IDLE)
                : (rd_state == ARB_ADDR) ? (ar_go ? ARB_RESP : ARB_ADDR)
                : (r_go ? ARB_IDLE : ARB_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= ARB_IDLE;
            wr_ptr   <= IW'(N - 1);
            wr_grant <= '0;
            wr_oh    <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_next;
            if (wr_state == ARB_IDLE && wr_req_any) begin
                wr_grant <= wr_pick;
                wr_oh    <= wr_pick_oh;
            end
            aw_done <= (wr_state == ARB_ADDR) & (aw_done | aw_go);
            w_done  <= (wr_state == ARB_ADDR) & (w_done | w_go);
            if (b_go) wr_ptr <= wr_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= ARB_IDLE;
            rd_ptr   <= IW'(N - 1);
            rd_grant <= '0;
            rd_oh    <= '0;
        end else begin
            rd_state <= rd_next;
            if (rd_state == ARB_IDLE && rd_req_any) begin
                rd_grant <= rd_pick;
                rd_oh    <= rd_pick_oh;
            end
            if (r_go) rd_ptr <= rd_grant;
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed checks of the 2-master AXI-Lite arbiter
module tb_axi_lite_arbiter;
    import axi_lite_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) up_if [2] ();
    axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) down_if ();

    logic [0:0] wr_grant, rd_grant;

    axi_lite_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(48), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .up(up_if), .down(down_if),
        .wr_grant(wr_grant), .rd_grant(rd_grant)
    );

    logic [1:0]  m_aw_valid = '0, m_w_valid = '0, m_ar_valid = '0;
    logic [47:0] m_aw_addr [2];
    logic [47:0] m_ar_addr [2];
    logic [63:0] m_w_data [2];
    logic [1:0]  u_aw_ready, u_w_ready, u_ar_ready, u_b_valid, u_r_valid;
    resp_t       u_b_resp [2];
    resp_t       u_r_resp [2];
    logic [63:0] u_r_data [2];

    for (genvar i = 0; i < 2; i++) begin : g_m
        assign up_if[i].aw_valid = m_aw_valid[i];
        assign up_if[i].aw_addr  = m_aw_addr[i];
        assign up_if[i].aw_prot  = 3'(i);
        assign up_if[i].w_valid  = m_w_valid[i];
        assign up_if[i].w_data   = m_w_data[i];
        assign up_if[i].w_strb   = 8'hFF;
        assign up_if[i].b_ready  = 1'b1;
        assign up_if[i].ar_valid = m_ar_valid[i];
        assign up_if[i].ar_addr  = m_ar_addr[i];
        assign up_if[i].ar_prot  = 3'(i);
        assign up_if[i].r_ready  = 1'b1;
        assign u_aw_ready[i] = up_if[i].aw_ready;
        assign u_w_ready[i]  = up_if[i].w_ready;
        assign u_ar_ready[i] = up_if[i].ar_ready;
        assign u_b_valid[i]  = up_if[i].b_valid;
        assign u_r_valid[i]  = up_if[i].r_valid;
        assign u_b_resp[i]   = up_if[i].b_resp;
        assign u_r_resp[i]   = up_if[i].r_resp;
        assign u_r_data[i]   = up_if[i].r_data;
    end

    // downstream slave model: B after both AW and W captured, R after AR
    logic        s_aw_ready = 1'b1, s_w_ready = 1'b1, s_ar_ready = 1'b1, s_b_en = 1'b1;
    resp_t       s_bresp = RESP_OKAY, s_rresp = RESP_OKAY;
    logic [63:0] s_rdata = '0;
    logic        s_bv, s_rv, aw_p, w_p, ar_p;

    assign down_if.aw_ready = s_aw_ready;
    assign down_if.w_ready  = s_w_ready;
    assign down_if.ar_ready = s_ar_ready;
    assign down_if.b_valid  = s_bv;
    assign down_if.b_resp   = s_bresp;
    assign down_if.r_valid  = s_rv;
    assign down_if.r_data   = s_rdata;
    assign down_if.r_resp   = s_rresp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_bv <= 1'b0; s_rv <= 1'b0; aw_p <= 1'b0; w_p <= 1'b0; ar_p <= 1'b0;
        end else begin
            if (down_if.aw_valid && s_aw_ready) aw_p <= 1'b1;
            if (down_if.w_valid && s_w_ready) w_p <= 1'b1;
            if (down_if.ar_valid && s_ar_ready) ar_p <= 1'b1;
            if (s_bv && down_if.b_ready) s_bv <= 1'b0;
            else if (aw_p && w_p && s_b_en) begin s_bv <= 1'b1; aw_p <= 1'b0; w_p <= 1'b0; end
            if (s_rv && down_if.r_ready) s_rv <= 1'b0;
            else if (ar_p) begin s_rv <= 1'b1; ar_p <= 1'b0; end
        end
    end

    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, glog_n = 0, wlog_n = 0;
    logic [47:0] last_aw_addr, last_ar_addr;
    logic [63:0] last_w_data;
    logic [7:0]  last_w_strb;
    logic [0:0]  glog [32];
    logic [63:0] wlog [32];

    always @(posedge clk) begin
        if (down_if.aw_valid && down_if.aw_ready) begin
            aw_cnt <= aw_cnt + 1;
            last_aw_addr <= down_if.aw_addr;
            if (glog_n < 32) begin glog[glog_n] <= wr_grant; glog_n <= glog_n + 1; end
        end
        if (down_if.w_valid && down_if.w_ready) begin
            w_cnt <= w_cnt + 1;
            last_w_data <= down_if.w_data;
            last_w_strb <= down_if.w_strb;
            if (wlog_n < 32) begin wlog[wlog_n] <= down_if.w_data; wlog_n <= wlog_n + 1; end
        end
        if (down_if.ar_valid && down_if.ar_ready) begin
            ar_cnt <= ar_cnt + 1;
            last_ar_addr <= down_if.ar_addr;
        end
        if (down_if.b_valid && down_if.b_ready) b_cnt <= b_cnt + 1;
    end

    int multi = 0, par_cnt = 0;
    int mr_cnt [2] = '{0, 0};
    always @(negedge clk) begin
        if ((&(u_aw_ready | u_w_ready | u_b_valid)) || (&(u_ar_ready | u_r_valid))) multi <= multi + 1;
        if (down_if.aw_valid && down_if.ar_valid) par_cnt <= par_cnt + 1;
        for (int i = 0; i < 2; i++) if (u_r_valid[i]) mr_cnt[i] <= mr_cnt[i] + 1;
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic obs(input int k, input int m);
        return k == 0 ? u_aw_ready[m] : k == 1 ? u_w_ready[m] : k == 2 ? u_ar_ready[m]
             : k == 3 ? u_b_valid[m] : u_r_valid[m];
    endfunction

    task automatic wait_obs(input string tag, input int k, input int m);
        int n = 0;
        do begin @(negedge clk); n++; end while (!obs(k, m) && n < 60);
        if (!obs(k, m)) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic send_aw_w(input int m, input logic [47:0] a, input logic [63:0] d, input int lead);
        fork
            begin
                m_w_data[m] = d;
                m_w_valid[m] = 1'b1;
                wait_obs("w", 1, m);
                @(posedge clk); #1 m_w_valid[m] = 1'b0;
            end
            begin
                if (lead > 0) begin repeat (lead) @(posedge clk); #1; end
                m_aw_addr[m] = a;
                m_aw_valid[m] = 1'b1;
                wait_obs("aw", 0, m);
                @(posedge clk); #1 m_aw_valid[m] = 1'b0;
            end
        join
    endtask

    task automatic do_write(input int m, input logic [47:0] a, input logic [63:0] d, input int lead,
                            output resp_t r);
        send_aw_w(m, a, d, lead);
        wait_obs("b", 3, m);
        r = u_b_resp[m];
        @(posedge clk); #1;
    endtask

    task automatic do_read(input int m, input logic [47:0] a, output logic [63:0] d, output resp_t r);
        m_ar_addr[m] = a;
        m_ar_valid[m] = 1'b1;
        wait_obs("ar", 2, m);
        @(posedge clk); #1 m_ar_valid[m] = 1'b0;
        wait_obs("r", 4, m);
        d = u_r_data[m];
        r = u_r_resp[m];
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t r0, r1, rr;
        logic [63:0] rd;
        int a0, w0, b0, g0, p0, c0, c1;
        m_aw_addr = '{48'h0, 48'h0};
        m_ar_addr = '{48'h0, 48'h0};
        m_w_data  = '{64'h0, 64'h0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_up_ready", {u_aw_ready, u_w_ready, u_ar_ready}, 64'h0);
        check("rst_up_valid", {u_b_valid, u_r_valid}, 64'h0);
        check("rst_down", {down_if.aw_valid, down_if.w_valid, down_if.b_ready, down_if.ar_valid, down_if.r_ready}, 64'h0);
        check("rst_grants", {wr_grant, rd_grant}, 64'h0);
        @(posedge clk); #1 rst = 1'b0;

        do_write(0, 48'h100, 64'hDEAD, 0, r0);
        check("w1_bresp", r0, RESP_OKAY);
        check("w1_aw_addr", last_aw_addr, 64'h100);
        check("w1_w_data", last_w_data, 64'hDEAD);
        check("w1_w_strb", last_w_strb, 64'hFF);
        check("w1_grant", wr_grant, 64'd0);
        check("w1_counts", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]}, 64'h010101);

        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        g0 = glog_n;
        for (int k = 0; k < 4; k++) begin
            fork
                do_write(0, 48'h1000 + 48'(k), 64'hA0 + 64'(k), 0, r0);
                do_write(1, 48'h2000 + 48'(k), 64'hB0 + 64'(k), 0, r1);
            join
        end
        for (int j = 0; j < 8; j++) begin
            check($sformatf("alt_grant%0d", j), glog[g0 + j], 64'(j % 2));
            check($sformatf("alt_data%0d", j), wlog[g0 + j], ((j % 2) != 0 ? 64'hB0 : 64'hA0) + 64'(j / 2));
        end
        check("alt_no_overlap", multi, 64'd0);

        a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        s_aw_ready = 1'b0;
        s_bresp = RESP_SLVERR;
        fork
            do_write(1, 48'h400, 64'h1234, 3, r1);
            begin repeat (8) @(posedge clk); #1 s_aw_ready = 1'b1; end
        join
        check("wlead_aw_once", aw_cnt - a0, 64'd1);
        check("wlead_w_once", w_cnt - w0, 64'd1);
        check("wlead_b_once", b_cnt - b0, 64'd1);
        check("wlead_bresp", r1, RESP_SLVERR);
        check("wlead_addr", last_aw_addr, 64'h400);
        check("wlead_grant", wr_grant, 64'd1);
        s_bresp = RESP_OKAY;

        s_rdata = 64'hBEEF;
        c0 = mr_cnt[0]; c1 = mr_cnt[1]; p0 = par_cnt;
        fork
            do_read(1, 48'h200, rd, rr);
            do_write(0, 48'h300, 64'h5555, 0, r0);
        join
        check("par_rdata", rd, 64'hBEEF);
        check("par_rresp", rr, RESP_OKAY);
        check("par_r_m0_none", mr_cnt[0] - c0, 64'd0);
        check("par_r_m1_one", mr_cnt[1] - c1, 64'd1);
        check("par_ar_addr", last_ar_addr, 64'h200);
        check("par_aw_addr", last_aw_addr, 64'h300);
        check("par_overlap", par_cnt > p0, 64'd1);
        check("par_rd_grant", rd_grant, 64'd1);
        check("par_bresp", r0, RESP_OKAY);

        s_rresp = RESP_DECERR;
        s_rdata = 64'h77;
        do_read(0, 48'h500, rd, rr);
        check("decerr_resp", rr, RESP_DECERR);
        check("decerr_grant", rd_grant, 64'd0);
        s_rresp = RESP_OKAY;
        s_rdata = 64'h99;
        do_read(1, 48'h600, rd, rr);
        check("after_decerr_resp", rr, RESP_OKAY);
        check("after_decerr_data", rd, 64'h99);
        check("after_decerr_grant", rd_grant, 64'd1);

        s_b_en = 1'b0;
        send_aw_w(1, 48'h700, 64'h4242, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("wresp_b_ready", down_if.b_ready, 64'd1);
        check("wresp_grant", wr_grant, 64'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_up", {u_aw_ready, u_w_ready, u_b_valid, u_ar_ready, u_r_valid}, 64'h0);
        check("mid_rst_down", {down_if.aw_valid, down_if.w_valid, down_if.b_ready, down_if.ar_valid, down_if.r_ready}, 64'h0);
        check("mid_rst_grant", wr_grant, 64'd0);
        s_b_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        g0 = glog_n;
        fork
            do_write(0, 48'h800, 64'hC0, 0, r0);
            do_write(1, 48'h900, 64'hC1, 0, r1);
        join
        check("post_rst_first", glog[g0], 64'd0);
        check("post_rst_second", glog[g0 + 1], 64'd1);
        check("post_rst_no_overlap", multi, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
